// File: rtl/pla_cfg_pkg.sv
// Shared types and sizing for the PLA configuration loader.
// Frame layout: CFG_BYTES config bytes followed by one XOR checksum byte.
package pla_cfg_pkg;

    localparam int unsigned NUM_IN_DEF    = 3;
    localparam int unsigned NUM_TERMS_DEF = 4;
    localparam int unsigned NUM_OUT_DEF   = 2;
    localparam int unsigned CFG_BYTES     = 4;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned CNT_W         = 2;
    localparam int unsigned SHADOW_W      = CFG_BYTES * BYTE_W;
    localparam int unsigned AND_W_DEF     = NUM_TERMS_DEF * 2 * NUM_IN_DEF;
    localparam int unsigned OR_W_DEF      = NUM_OUT_DEF * NUM_TERMS_DEF;
    // OR-plane fuses live in the last config byte
    localparam int unsigned OR_LSB        = BYTE_W * (CFG_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/pla_cfg_loader_if.sv
// Byte-stream configuration port: frame start strobe plus valid/ready byte handshake.
interface pla_cfg_loader_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output start, output in_valid, output in_data, input in_ready);
    modport slave  (input start, input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pla_cfg_loader.sv
// Loads a checksum-protected PLA fuse frame into a shadow register and
// commits AND/OR planes atomically only when the XOR checksum matches.
module pla_cfg_loader
    import pla_cfg_pkg::*;
#(
    parameter int unsigned NUM_IN    = NUM_IN_DEF,
    parameter int unsigned NUM_TERMS = NUM_TERMS_DEF,
    parameter int unsigned NUM_OUT   = NUM_OUT_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    pla_cfg_loader_if.slave                 bus,
    output logic [NUM_TERMS*2*NUM_IN-1:0]   and_plane,
    output logic [NUM_OUT*NUM_TERMS-1:0]    or_plane,
    output logic                            cfg_valid,
    output logic                            busy,
    output logic                            error
);

    localparam int unsigned AND_W = NUM_TERMS * 2 * NUM_IN;
    localparam int unsigned OR_W  = NUM_OUT * NUM_TERMS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BYTES - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [SHADOW_W-1:0]  shadow;
    logic [BYTE_W-1:0]    csum;
    logic                 accept;

    // start overrides any handshake in the same cycle
    assign bus.in_ready = ((state == ST_LOAD) || (state == ST_CHECK)) && !bus.start;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shadow    <= '0;
            csum      <= '0;
            and_plane <= '0;
            or_plane  <= '0;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else if (bus.start) begin
            state  <= ST_LOAD;
            cnt    <= '0;
            shadow <= '0;
            csum   <= '0;
            error  <= 1'b0;
            busy   <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        shadow[{cnt, 3'b000} +: BYTE_W] <= bus.in_data;
                        csum <= csum ^ bus.in_data;
                        // counter parks on the last slot instead of wrapping
                        if (cnt == LAST_CNT) begin
                            state <= ST_CHECK;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (bus.in_data == csum) begin
                            state     <= ST_DONE;
                            and_plane <= shadow[AND_W-1:0];
                            or_plane  <= shadow[OR_LSB +: OR_W];
                            cfg_valid <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pla_cfg_loader.sv
// Self-checking bench: directed frames plus randomized frames against a frame-level model.
module tb_pla_cfg_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] and_plane;
    logic [7:0]  or_plane;
    logic        cfg_valid, busy, error;

    int n_chk  = 0;
    int n_fail = 0;

    logic [23:0] m_and;
    logic [7:0]  m_or;
    logic        m_cv, m_err;

    always #5 clk = ~clk;

    pla_cfg_loader_if bus();

    pla_cfg_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .and_plane (and_plane),
        .or_plane  (or_plane),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .error     (error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bus.in_valid = 1'b0;
        repeat (gap) step();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready byte=%02h got in_ready=%b want 1", b, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (2) step();
        n_chk++;
        if ({and_plane, or_plane, cfg_valid, busy, error, bus.in_ready} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got and=%h or=%h cv=%b busy=%b err=%b rdy=%b want all 0",
                     and_plane, or_plane, cfg_valid, busy, error, bus.in_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle_ignore();
        bus.in_valid = 1'b1; bus.in_data = 8'hFF;
        repeat (3) begin
            #1;
            n_chk++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL idle_ready got %b want 0", bus.in_ready);
            end
            step();
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if ({and_plane, or_plane, cfg_valid, busy, error} !== 35'h0) begin
            n_fail++;
            $display("FAIL idle_state got and=%h or=%h cv=%b busy=%b err=%b want all 0",
                     and_plane, or_plane, cfg_valid, busy, error);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] fr [5] = '{8'h56, 8'h56, 8'h6A, 8'hC3, 8'hA9};
        start_pulse();
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_load got %b want 1", busy); end
        for (int i = 0; i < 5; i++) send_byte(fr[i], 0);
        n_chk++;
        if (and_plane !== 24'h6A5656 || or_plane !== 8'hC3 || cfg_valid !== 1'b1 ||
            busy !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL good_commit got and=%h or=%h cv=%b busy=%b err=%b want 6a5656 c3 1 0 0",
                     and_plane, or_plane, cfg_valid, busy, error);
        end
    endtask

    task automatic test_bad_frame();
        start_pulse();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n_chk++;
        if (and_plane !== 24'h6A5656 || cfg_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_hold_midframe got and=%h cv=%b busy=%b want 6a5656 1 1",
                     and_plane, cfg_valid, busy);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        n_chk++;
        if (error !== 1'b1 || cfg_valid !== 1'b1 || and_plane !== 24'h6A5656 ||
            or_plane !== 8'hC3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_result got err=%b cv=%b and=%h or=%h busy=%b want 1 1 6a5656 c3 0",
                     error, cfg_valid, and_plane, or_plane, busy);
        end
        repeat (3) step();
        n_chk++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", error); end
        start_pulse();
        n_chk++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL err_clear_on_start got err=%b busy=%b want 0 1", error, busy);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] fr [5] = '{8'h56, 8'h56, 8'h6A, 8'hC3, 8'hA9};
        start_pulse();
        for (int i = 0; i < 5; i++) send_byte(fr[i], $urandom_range(0, 4));
        repeat ($urandom_range(1, 3)) step();
        n_chk++;
        if (and_plane !== 24'h6A5656 || or_plane !== 8'hC3 || cfg_valid !== 1'b1 ||
            busy !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_commit got and=%h or=%h cv=%b busy=%b err=%b want 6a5656 c3 1 0 0",
                     and_plane, or_plane, cfg_valid, busy, error);
        end
    endtask

    task automatic test_restart();
        logic [7:0] fr [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        start_pulse();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h33;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL restart_ready got %b want 0", bus.in_ready);
        end
        step();
        bus.start = 1'b0; bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(fr[i], 0);
        n_chk++;
        if (and_plane !== 24'h040201 || or_plane !== 8'h08 || cfg_valid !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_commit got and=%h or=%h cv=%b err=%b want 040201 08 1 0",
                     and_plane, or_plane, cfg_valid, error);
        end
    endtask

    task automatic test_rst_midframe();
        start_pulse();
        send_byte(8'h56, 0);
        send_byte(8'h56, 0);
        send_byte(8'h6A, 0);
        rst = 1'b1;
        #2;
        n_chk++;
        if ({and_plane, or_plane, cfg_valid, busy, error, bus.in_ready} !== 36'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got and=%h or=%h cv=%b busy=%b err=%b rdy=%b want all 0",
                     and_plane, or_plane, cfg_valid, busy, error, bus.in_ready);
        end
        step();
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hC3;
        step();
        bus.in_data = 8'hA9;
        repeat (2) step();
        bus.in_valid = 1'b0;
        n_chk++;
        if ({and_plane, or_plane, cfg_valid, busy, error, bus.in_ready} !== 36'h0) begin
            n_fail++;
            $display("FAIL rst_mid_ignore got and=%h or=%h cv=%b busy=%b err=%b rdy=%b want all 0",
                     and_plane, or_plane, cfg_valid, busy, error, bus.in_ready);
        end
        m_and = '0; m_or = '0; m_cv = 1'b0; m_err = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  b [5];
        logic [7:0]  sum;
        bit          abort;
        int unsigned nb;
        for (int f = 0; f < 40; f++) begin
            start_pulse();
            m_err = 1'b0;
            n_chk++;
            if (busy !== 1'b1 || error !== 1'b0) begin
                n_fail++; $display("FAIL rand_start f=%0d got busy=%b err=%b want 1 0", f, busy, error);
            end
            sum = 8'h00;
            for (int i = 0; i < 4; i++) begin
                b[i] = 8'($urandom);
                sum  = sum ^ b[i];
            end
            b[4]  = ($urandom_range(0, 1) == 0) ? sum : (sum ^ 8'($urandom_range(1, 255)));
            abort = ($urandom_range(0, 6) == 0);
            nb    = abort ? $urandom_range(0, 4) : 5;
            for (int i = 0; i < int'(nb); i++) send_byte(b[i], $urandom_range(0, 2));
            if (!abort) begin
                if (b[4] == sum) begin
                    m_and = {b[2], b[1], b[0]};
                    m_or  = b[3];
                    m_cv  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            n_chk++;
            if (and_plane !== m_and || or_plane !== m_or || cfg_valid !== m_cv ||
                error !== m_err || busy !== abort) begin
                n_fail++;
                $display("FAIL rand_frame f=%0d got and=%h or=%h cv=%b err=%b busy=%b want %h %h %b %b %b",
                         f, and_plane, or_plane, cfg_valid, error, busy, m_and, m_or, m_cv, m_err, abort);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_good_frame();
        test_bad_frame();
        test_gaps();
        test_restart();
        test_rst_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
